cmd_frame_ctrl: RTL
===================

Name: cmd_frame_ctrl

Overview:
Command-frame controller in the REF_CLK domain. It sits directly downstream of the UART-RX data synchronizer and consumes its synchronized byte plus its one-cycle valid pulse. It parses multi-byte command frames, drives register-file writes and reads, and launches ALU operations. It returns read data and ALU results as bytes to the TX FIFO.

Parameters:
DATA_WIDTH, 8, byte / register-file data width
ADDR_WIDTH, 4, register-file address width
ALU_FUN_WIDTH, 4, ALU function-select width
TIMEOUT_CYCLES, 255, maximum wait for RF_RD_VLD / ALU_OUT_VLD before abort

Ports:
CLK  in  1  REF_CLK
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  synchronized received byte
RX_D_VLD  in  1  one-cycle valid pulse for RX_P_DATA
RF_RD_DATA  in  DATA_WIDTH  register-file read data
RF_RD_VLD  in  1  register-file read data valid
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid
FIFO_FULL  in  1  TX FIFO full
RF_ADDR  out  ADDR_WIDTH  register-file address
RF_WR_EN  out  1  one-cycle write strobe
RF_RD_EN  out  1  one-cycle read strobe
RF_WR_DATA  out  DATA_WIDTH  write data
ALU_EN  out  1  one-cycle ALU start strobe
ALU_FUN  out  ALU_FUN_WIDTH  ALU function select
CLK_GATE_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  out  1  one-cycle TX FIFO write strobe
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- Reset: RST is asynchronous and active-low. It forces state IDLE, clears the timeout counter, and drives every output to 0. Reset asserted mid-frame aborts the frame with no strobes issued. The first byte after reset release is parsed as a command.
- All outputs are registered. A strobe caused by the RX_D_VLD sampled at edge n is high for exactly one cycle, between edge n+1 and edge n+2.
- Command bytes, decoded in IDLE:
  - 0xAA: write, frame = cmd, addr, data.
  - 0xBB: read, frame = cmd, addr.
  - 0xCC: ALU with operands, frame = cmd, A, B, fun.
  - 0xDD: ALU without operands, frame = cmd, fun.
  - Any other byte in IDLE: CMD_ERR pulse, stay in IDLE.
- Addresses use RX byte bits [ADDR_WIDTH-1:0]. ALU function uses bits [ALU_FUN_WIDTH-1:0]. Upper bits are ignored.
- States and transitions (each "byte" step advances only on RX_D_VLD):
  - IDLE: command byte selects the next state as listed above.
  - WR_ADDR: latch address -> WR_DATA.
  - WR_DATA: drive RF_WR_EN, RF_ADDR = latched address, RF_WR_DATA = byte -> IDLE.
  - RD_ADDR: drive RF_RD_EN, RF_ADDR = byte -> RD_WAIT.
  - RD_WAIT: on RF_RD_VLD, latch RF_RD_DATA -> TX_RD.
  - ALU_A: RF write to address 0 with the byte -> ALU_B.
  - ALU_B: RF write to address 1 with the byte -> ALU_FN.
  - ALU_FN: drive ALU_EN, ALU_FUN = byte -> ALU_WAIT.
  - ALU_WAIT: on ALU_OUT_VLD, latch the 2*DATA_WIDTH result -> TX_LSB.
  - TX_RD: send the latched byte -> IDLE.
  - TX_LSB: send result[DATA_WIDTH-1:0] -> TX_MSB.
  - TX_MSB: send result[2*DATA_WIDTH-1:DATA_WIDTH] -> IDLE.
- TX states: TX_D_VLD pulses for one cycle with TX_P_DATA only in a cycle where FIFO_FULL is 0. While FIFO_FULL is 1 the state holds and no strobe is issued. A TX_P_DATA value is never written twice.
- CLK_GATE_EN is 1 whenever state is ALU_FN or ALU_WAIT, including the ALU_EN cycle; otherwise 0. It goes high the cycle after the 0xDD byte, or the cycle after the B byte for 0xCC. It drops the cycle after leaving ALU_WAIT.
- Timeout: a counter clears on entry to RD_WAIT or ALU_WAIT and increments each cycle while in that state. When it reaches TIMEOUT_CYCLES with no valid: CMD_ERR pulse, return to IDLE, no TX. A valid arriving in the same cycle as expiry wins.
- RX_D_VLD in RD_WAIT, ALU_WAIT, or any TX state: the byte is dropped, with no CMD_ERR and no state change.
- The RF_RD_VLD / ALU_OUT_VLD inputs are ignored outside their wait state.
- RF_WR_EN and RF_RD_EN are never high in the same cycle. ALU_EN is never high in the same cycle as an RF strobe.

Test Plan:
- Write then read: frame AA,05,3C, then frame BB,05. RF model returns 3C with RF_RD_VLD 1 cycle after RF_RD_EN. Required: RF_WR_EN one cycle with addr 5 / data 3C; RF_RD_EN one cycle with addr 5; one TX_D_VLD with 3C; state back to IDLE.
- ALU with operands: frame CC,12,34,01. ALU_OUT = 0x0246 valid 2 cycles after ALU_EN. Required: RF writes to addr0 = 12 and addr1 = 34; ALU_EN with ALU_FUN = 1; CLK_GATE_EN high through ALU_WAIT; TX bytes 46 then 02.
- FIFO backpressure: frame DD,02 with FIFO_FULL held high for 5 cycles during TX_LSB. Required: no TX_D_VLD while full; the LSB byte is sent exactly once after release; the MSB follows.
- Illegal command and dropped bytes: byte 7E in IDLE gives CMD_ERR for one cycle and no other strobes. Bytes sent during ALU_WAIT are ignored, and the frame still completes correctly.
- Timeout: frame BB,03 with RF_RD_VLD never asserted. Required: CMD_ERR exactly TIMEOUT_CYCLES cycles after entry to RD_WAIT, no TX, IDLE. A following frame AA,01,FF then executes normally.
- Reset mid-frame: assert RST after AA,07. Required: all outputs 0 immediately and no RF_WR_EN. After release, frame AA,07,55 writes 55 to addr 7.

Source files
------------

// File: rtl/cmd_frame_ctrl.sv
// -----------------------------------------------------------------------------
// cmd_frame_ctrl
//   Command-frame controller (REF_CLK domain). Consumes synchronized UART-RX
//   bytes, parses multi-byte command frames, issues register-file writes and
//   reads, launches ALU operations and returns read data / ALU results to the
//   TX FIFO one byte at a time.
//
//   Frames (first byte decoded in IDLE):
//     0xAA addr data     register write
//     0xBB addr          register read, result byte sent to TX
//     0xCC A B fun       write A->RF[0], B->RF[1], start ALU, send 2 result bytes
//     0xDD fun           start ALU on current RF[0]/RF[1], send 2 result bytes
//     other              CMD_ERR pulse
//
// Ports:
//   CLK, RST          clock, asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle valid
//   RF_RD_DATA/RF_RD_VLD  register-file read response
//   ALU_OUT/ALU_OUT_VLD   ALU result response
//   FIFO_FULL           TX FIFO back-pressure
//   RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA   register-file request
//   ALU_EN, ALU_FUN, CLK_GATE_EN              ALU request / clock gate
//   TX_P_DATA, TX_D_VLD                       byte to TX FIFO
//   CMD_ERR                                   one-cycle error pulse
//
// All outputs are registered: each output flop loads the value decided by the
// same next-state logic that advances the FSM.
// -----------------------------------------------------------------------------
module cmd_frame_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
    input  logic                      RF_RD_VLD,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    input  logic                      FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]     RF_ADDR,
    output logic                      RF_WR_EN,
    output logic                      RF_RD_EN,
    output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
    output logic                      ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
    output logic                      CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    output logic                      CMD_ERR
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // The wait expires on the edge where the counter would reach
    // TIMEOUT_CYCLES, so CMD_ERR lands exactly TIMEOUT_CYCLES cycles after
    // entry to the wait state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_A = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_B = ADDR_WIDTH'(1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WR_ADDR  = 4'd1;
    localparam logic [3:0] WR_DATA  = 4'd2;
    localparam logic [3:0] RD_ADDR  = 4'd3;
    localparam logic [3:0] RD_WAIT  = 4'd4;
    localparam logic [3:0] ALU_A    = 4'd5;
    localparam logic [3:0] ALU_B    = 4'd6;
    localparam logic [3:0] ALU_FN   = 4'd7;
    localparam logic [3:0] ALU_WAIT = 4'd8;
    localparam logic [3:0] TX_RD    = 4'd9;
    localparam logic [3:0] TX_LSB   = 4'd10;
    localparam logic [3:0] TX_MSB   = 4'd11;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [3:0]                state_q,       state_d;
    logic [CNT_W-1:0]          cnt_q,         cnt_d;
    logic [ADDR_WIDTH-1:0]     wr_addr_q,     wr_addr_d;
    logic [DATA_WIDTH-1:0]     rd_byte_q,     rd_byte_d;
    logic [2*DATA_WIDTH-1:0]   alu_res_q,     alu_res_d;

    // Output registers
    logic [ADDR_WIDTH-1:0]     rf_addr_q,     rf_addr_d;
    logic                      rf_wr_en_q,    rf_wr_en_d;
    logic                      rf_rd_en_q,    rf_rd_en_d;
    logic [DATA_WIDTH-1:0]     rf_wr_data_q,  rf_wr_data_d;
    logic                      alu_en_q,      alu_en_d;
    logic [ALU_FUN_WIDTH-1:0]  alu_fun_q,     alu_fun_d;
    logic                      clk_gate_en_q, clk_gate_en_d;
    logic [DATA_WIDTH-1:0]     tx_p_data_q,   tx_p_data_d;
    logic                      tx_d_vld_q,    tx_d_vld_d;
    logic                      cmd_err_q,     cmd_err_d;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_addr_d    = wr_addr_q;
        rd_byte_d    = rd_byte_q;
        alu_res_d    = alu_res_q;

        // Data-type outputs hold their last value; strobes default low.
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        tx_p_data_d  = tx_p_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        tx_d_vld_d   = 1'b0;
        cmd_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_d = WR_ADDR;
                        CMD_RD:     state_d = RD_ADDR;
                        CMD_ALU_OP: state_d = ALU_A;
                        CMD_ALU_NO: state_d = ALU_FN;
                        default:    cmd_err_d = 1'b1;
                    endcase
                end
            end

            WR_ADDR: begin
                if (RX_D_VLD) begin
                    wr_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = WR_DATA;
                end
            end

            WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = wr_addr_q;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = IDLE;
                end
            end

            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    cnt_d      = '0;
                    state_d    = RD_WAIT;
                end
            end

            // RX bytes arriving here are dropped silently. A response in the
            // expiry cycle takes priority over the timeout.
            RD_WAIT: begin
                if (RF_RD_VLD) begin
                    rd_byte_d = RF_RD_DATA;
                    state_d   = TX_RD;
                end else if (cnt_q == CNT_LAST) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ALU_A: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_OP_A;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = ALU_B;
                end
            end

            ALU_B: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_OP_B;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = ALU_FN;
                end
            end

            ALU_FN: begin
                if (RX_D_VLD) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    cnt_d     = '0;
                    state_d   = ALU_WAIT;
                end
            end

            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    alu_res_d = ALU_OUT;
                    state_d   = TX_LSB;
                end else if (cnt_q == CNT_LAST) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // TX states advance only on a cycle the FIFO can accept, so each
            // byte is written exactly once.
            TX_RD: begin
                if (!FIFO_FULL) begin
                    tx_d_vld_d  = 1'b1;
                    tx_p_data_d = rd_byte_q;
                    state_d     = IDLE;
                end
            end

            TX_LSB: begin
                if (!FIFO_FULL) begin
                    tx_d_vld_d  = 1'b1;
                    tx_p_data_d = alu_res_q[DATA_WIDTH-1:0];
                    state_d     = TX_MSB;
                end
            end

            TX_MSB: begin
                if (!FIFO_FULL) begin
                    tx_d_vld_d  = 1'b1;
                    tx_p_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Registered from the next state so the gate tracks ALU_FN/ALU_WAIT
        // cycle-for-cycle with the state register.
        clk_gate_en_d = (state_d == ALU_FN) || (state_d == ALU_WAIT);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_addr_q     <= '0;
            rd_byte_q     <= '0;
            alu_res_q     <= '0;
            rf_addr_q     <= '0;
            rf_wr_en_q    <= 1'b0;
            rf_rd_en_q    <= 1'b0;
            rf_wr_data_q  <= '0;
            alu_en_q      <= 1'b0;
            alu_fun_q     <= '0;
            clk_gate_en_q <= 1'b0;
            tx_p_data_q   <= '0;
            tx_d_vld_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_addr_q     <= wr_addr_d;
            rd_byte_q     <= rd_byte_d;
            alu_res_q     <= alu_res_d;
            rf_addr_q     <= rf_addr_d;
            rf_wr_en_q    <= rf_wr_en_d;
            rf_rd_en_q    <= rf_rd_en_d;
            rf_wr_data_q  <= rf_wr_data_d;
            alu_en_q      <= alu_en_d;
            alu_fun_q     <= alu_fun_d;
            clk_gate_en_q <= clk_gate_en_d;
            tx_p_data_q   <= tx_p_data_d;
            tx_d_vld_q    <= tx_d_vld_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign RF_ADDR     = rf_addr_q;
    assign RF_WR_EN    = rf_wr_en_q;
    assign RF_RD_EN    = rf_rd_en_q;
    assign RF_WR_DATA  = rf_wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = clk_gate_en_q;
    assign TX_P_DATA   = tx_p_data_q;
    assign TX_D_VLD    = tx_d_vld_q;
    assign CMD_ERR     = cmd_err_q;

endmodule
